if_stage: RTL and testbench

Parametrised instruction-fetch stage for the xgriscv pipeline. It replaces the bare PC register with a PC, IF/ID pipeline register, stall and redirect handling, and a debug run/step/halt mode driven from board switches. It drives the word address of the asynchronous-read instruction ROM and captures the returned word into IF/ID. It also exports a PC, valid flag and fetch counter for the seg7 display mux.

---
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, IF/ID register, stall/redirect priority and
// debug run/step/halt control with a fetch counter for the display mux.
module if_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     IMEM_AW  = 6,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [1:0]         mode_i,
  input  logic               step_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_data_i,
  output logic [XLEN-1:0]    pc_o,
  output logic               if_id_valid_o,
  output logic [XLEN-1:0]    if_id_pc_o,
  output logic [31:0]        if_id_instr_o,
  output logic               misalign_o,
  output logic [CNT_W-1:0]   fetch_count_o
);

  // Step request FSM
  //   state   | meaning
  //   ST_IDLE | no step fetch outstanding
  //   ST_PEND | one step fetch requested, waiting for an unstalled cycle
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } step_st_e;

  localparam logic [XLEN-1:0]  PC_INC  = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  step_st_e          step_st_q, step_st_d;
  logic              step_q_q, step_q_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic mode_run;
  logic mode_step;
  logic step_rise;
  logic step_pend;
  logic go;
  logic fetch;

  assign mode_run  = (mode_i == 2'b00);
  assign mode_step = (mode_i == 2'b01);
  assign step_rise = step_i & ~step_q_q;
  assign step_pend = (step_st_q == ST_PEND);
  assign go        = mode_run | (mode_step & (step_rise | step_pend));
  assign fetch     = ~redirect_i & ~stall_i & go;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_st_q <= ST_IDLE;
    end else begin
      step_st_q <= step_st_d;
    end
  end

  // Next-state: a pending step survives stalls and redirects, is consumed
  // by the first real fetch, and is dropped as soon as step mode is left.
  always_comb begin
    step_st_d = step_st_q;
    if (!mode_step) begin
      step_st_d = ST_IDLE;
    end else begin
      case (step_st_q)
        ST_IDLE: begin
          if (step_rise && !fetch) begin
            step_st_d = ST_PEND;
          end
        end
        ST_PEND: begin
          if (fetch) begin
            step_st_d = ST_IDLE;
          end
        end
        default: step_st_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next-state: redirect > stall > go > bubble
  always_comb begin
    step_q_d      = step_i;
    pc_d          = pc_q;
    valid_d       = valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    misalign_d    = misalign_q;
    count_d       = count_q;
    if (redirect_i) begin
      pc_d       = {redirect_pc_i[XLEN-1:2], 2'b00};
      valid_d    = 1'b0;
      misalign_d = misalign_q | (redirect_pc_i[1:0] != 2'b00);
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (go) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_data_i;
      valid_d       = 1'b1;
      pc_d          = pc_q + PC_INC;
      count_d       = count_q + CNT_INC;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_q_q      <= 1'b0;
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      misalign_q    <= 1'b0;
      count_q       <= '0;
    end else begin
      step_q_q      <= step_q_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      misalign_q    <= misalign_d;
      count_q       <= count_d;
    end
  end

  // Output decode; the ROM address drops the upper PC bits and wraps.
  always_comb begin
    imem_addr_o   = pc_q[IMEM_AW+1:2];
    pc_o          = pc_q;
    if_id_valid_o = valid_q;
    if_id_pc_o    = if_id_pc_q;
    if_id_instr_o = if_id_instr_q;
    misalign_o    = misalign_q;
    fetch_count_o = count_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: run, stall, redirect, misalign, halt, step,
// ROM address wrap and asynchronous reset, with hand-computed expectations.
module tb_if_stage;

  logic        clk;
  logic        rstn;
  logic [1:0]  mode_i;
  logic        step_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        misalign_o;
  logic [15:0] fetch_count_o;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk           (clk),
    .rstn          (rstn),
    .mode_i        (mode_i),
    .step_i        (step_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .pc_o          (pc_o),
    .if_id_valid_o (if_id_valid_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_instr_o (if_id_instr_o),
    .misalign_o    (misalign_o),
    .fetch_count_o (fetch_count_o)
  );

  // ROM[i] = 0x1000_0000 + i
  assign imem_data_i = 32'h1000_0000 + {26'b0, imem_addr_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn          = 1'b0;
    mode_i        = 2'b00;
    step_i        = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    #2;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("rst_if_id_pc", if_id_pc_o, 32'h0);
    chk("rst_instr", if_id_instr_o, 32'h0);
    chk("rst_misalign", {31'b0, misalign_o}, 32'h0);
    chk("rst_count", {16'b0, fetch_count_o}, 32'h0);
    chk("rst_addr", {26'b0, imem_addr_o}, 32'h0);
    #10;
    rstn = 1'b1;

    // Run
    tick();
    chk("run1_pc", pc_o, 32'h4);
    chk("run1_valid", {31'b0, if_id_valid_o}, 32'h1);
    chk("run1_if_id_pc", if_id_pc_o, 32'h0);
    chk("run1_instr", if_id_instr_o, 32'h1000_0000);
    chk("run1_count", {16'b0, fetch_count_o}, 32'h1);
    tick(); tick(); tick(); tick();
    chk("run5_pc", pc_o, 32'h14);
    chk("run5_if_id_pc", if_id_pc_o, 32'h10);
    chk("run5_instr", if_id_instr_o, 32'h1000_0004);
    chk("run5_count", {16'b0, fetch_count_o}, 32'h5);

    // Stall three cycles at pc 0x14
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc_o, 32'h14);
      chk("stall_if_id_pc", if_id_pc_o, 32'h10);
      chk("stall_valid", {31'b0, if_id_valid_o}, 32'h1);
      chk("stall_count", {16'b0, fetch_count_o}, 32'h5);
    end
    stall_i = 1'b0;
    tick();
    chk("unstall_pc", pc_o, 32'h18);
    chk("unstall_if_id_pc", if_id_pc_o, 32'h14);
    chk("unstall_instr", if_id_instr_o, 32'h1000_0005);
    chk("unstall_count", {16'b0, fetch_count_o}, 32'h6);

    // Redirect overrides stall
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    stall_i       = 1'b1;
    tick();
    chk("redir_pc", pc_o, 32'h40);
    chk("redir_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("redir_if_id_pc_held", if_id_pc_o, 32'h14);
    chk("redir_count", {16'b0, fetch_count_o}, 32'h6);
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    tick();
    chk("redir2_pc", pc_o, 32'h44);
    chk("redir2_if_id_pc", if_id_pc_o, 32'h40);
    chk("redir2_instr", if_id_instr_o, 32'h1000_0010);
    chk("redir2_valid", {31'b0, if_id_valid_o}, 32'h1);
    chk("redir2_misalign", {31'b0, misalign_o}, 32'h0);

    // Misaligned redirect target
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h42;
    tick();
    chk("mis_pc", pc_o, 32'h40);
    chk("mis_flag", {31'b0, misalign_o}, 32'h1);
    chk("mis_valid", {31'b0, if_id_valid_o}, 32'h0);
    redirect_i = 1'b0;
    tick();
    chk("mis_sticky", {31'b0, misalign_o}, 32'h1);
    chk("mis2_pc", pc_o, 32'h44);
    chk("mis2_count", {16'b0, fetch_count_o}, 32'h8);

    // Halt, both encodings
    mode_i = 2'b10;
    tick();
    chk("halt_pc", pc_o, 32'h44);
    chk("halt_valid", {31'b0, if_id_valid_o}, 32'h0);
    tick();
    chk("halt2_pc", pc_o, 32'h44);
    mode_i = 2'b11;
    tick();
    chk("halt3_pc", pc_o, 32'h44);
    chk("halt3_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("halt_count", {16'b0, fetch_count_o}, 32'h8);
    mode_i = 2'b00;
    tick();
    chk("resume_pc", pc_o, 32'h48);
    chk("resume_if_id_pc", if_id_pc_o, 32'h44);
    chk("resume_valid", {31'b0, if_id_valid_o}, 32'h1);
    chk("resume_count", {16'b0, fetch_count_o}, 32'h9);

    // Step mode: level held high gives one fetch
    mode_i = 2'b01;
    tick();
    chk("step_idle_pc", pc_o, 32'h48);
    chk("step_idle_valid", {31'b0, if_id_valid_o}, 32'h0);
    step_i = 1'b1;
    tick();
    chk("step_pc", pc_o, 32'h4c);
    chk("step_if_id_pc", if_id_pc_o, 32'h48);
    chk("step_valid", {31'b0, if_id_valid_o}, 32'h1);
    chk("step_count", {16'b0, fetch_count_o}, 32'ha);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("step_hold_valid", {31'b0, if_id_valid_o}, 32'h0);
    end
    chk("step_hold_pc", pc_o, 32'h4c);
    chk("step_hold_count", {16'b0, fetch_count_o}, 32'ha);
    step_i = 1'b0;
    tick();

    // Step rise during stall is latched
    stall_i = 1'b1;
    step_i  = 1'b1;
    tick();
    chk("stepst_pc", pc_o, 32'h4c);
    tick();
    chk("stepst2_pc", pc_o, 32'h4c);
    chk("stepst2_count", {16'b0, fetch_count_o}, 32'ha);
    stall_i = 1'b0;
    tick();
    chk("stepst_fetch_pc", pc_o, 32'h50);
    chk("stepst_fetch_if_id_pc", if_id_pc_o, 32'h4c);
    chk("stepst_fetch_valid", {31'b0, if_id_valid_o}, 32'h1);
    chk("stepst_fetch_count", {16'b0, fetch_count_o}, 32'hb);
    tick();
    chk("stepst_once_pc", pc_o, 32'h50);
    chk("stepst_once_valid", {31'b0, if_id_valid_o}, 32'h0);
    step_i = 1'b0;

    // ROM address wrap past pc 0xFC
    mode_i        = 2'b00;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hf8;
    tick();
    redirect_i = 1'b0;
    chk("wrap0_addr", {26'b0, imem_addr_o}, 32'd62);
    tick();
    chk("wrap1_pc", pc_o, 32'hfc);
    chk("wrap1_addr", {26'b0, imem_addr_o}, 32'd63);
    tick();
    chk("wrap2_pc", pc_o, 32'h100);
    chk("wrap2_addr", {26'b0, imem_addr_o}, 32'd0);
    chk("wrap2_instr", if_id_instr_o, 32'h1000_003f);
    chk("wrap2_count", {16'b0, fetch_count_o}, 32'hd);
    tick();
    chk("wrap3_instr", if_id_instr_o, 32'h1000_0000);

    // Asynchronous reset between clock edges
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("arst_if_id_pc", if_id_pc_o, 32'h0);
    chk("arst_instr", if_id_instr_o, 32'h0);
    chk("arst_misalign", {31'b0, misalign_o}, 32'h0);
    chk("arst_count", {16'b0, fetch_count_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
